// File: rtl/pci_target_pkg.sv
// Shared constants for the PCI memory target: FSM state encodings, bus commands
// and register-file geometry.
package pci_target_pkg;

    localparam int unsigned RF_DEPTH = 4;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef logic [2:0] pci_state_t;

    localparam pci_state_t S_IDLE    = 3'd0;
    localparam pci_state_t S_WR_DATA = 3'd1;
    localparam pci_state_t S_RD_TAR  = 3'd2;
    localparam pci_state_t S_RD_DATA = 3'd3;
    localparam pci_state_t S_BACKOFF = 3'd4;
    localparam pci_state_t S_IGNORE  = 3'd5;

endpackage

// File: rtl/pci_target_regfile.sv
// 4x32 target register file: byte-enabled synchronous write, combinational read.
module pci_target_regfile
    import pci_target_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic [1:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [RF_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pci_target.sv
// Minimal PCI memory target: claims a 16-byte window, fast DEVSEL_, bursts with wrap
// over a 4-entry register file.
module pci_target
    import pci_target_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FRAME_,
    input  logic        IRDY_,
    input  logic [3:0]  C_BE_,
    input  logic [31:0] AD_in,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic        DEVSEL_,
    output logic        TRDY_
);

    pci_state_t  state_q, state_d;
    logic [1:0]  word_ptr_q, word_ptr_d;
    logic        frame_prev_q;
    logic        devsel_q, trdy_q, oe_q;
    logic        addr_phase, claim, xfer;
    logic [31:0] rf_rdata;

    assign addr_phase = (state_q == S_IDLE) && !FRAME_ && frame_prev_q;
    assign claim      = (AD_in[31:4] == BASE_ADDR[31:4]) &&
                        ((C_BE_ == CMD_MEM_READ) || (C_BE_ == CMD_MEM_WRITE));
    assign xfer       = ((state_q == S_WR_DATA) || (state_q == S_RD_DATA)) && !IRDY_ && !trdy_q;

    always_comb begin
        state_d    = state_q;
        word_ptr_d = word_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (addr_phase) begin
                    word_ptr_d = AD_in[3:2];
                    if (!claim)                       state_d = S_IGNORE;
                    else if (C_BE_ == CMD_MEM_WRITE)  state_d = S_WR_DATA;
                    else                              state_d = S_RD_TAR;
                end
            end
            S_WR_DATA, S_RD_DATA: begin
                if (xfer) begin
                    word_ptr_d = word_ptr_q + 2'd1;
                    if (FRAME_) state_d = S_BACKOFF;
                end
            end
            S_RD_TAR:  state_d = S_RD_DATA;
            S_BACKOFF: state_d = S_IDLE;
            S_IGNORE:  if (FRAME_ && IRDY_) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // frame_prev resets to 0 so a FRAME_ still low after reset is never taken as a new cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            word_ptr_q   <= '0;
            frame_prev_q <= 1'b0;
            devsel_q     <= 1'b1;
            trdy_q       <= 1'b1;
            oe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_ptr_q   <= word_ptr_d;
            frame_prev_q <= FRAME_;
            devsel_q     <= !(state_d inside {S_WR_DATA, S_RD_TAR, S_RD_DATA});
            trdy_q       <= !(state_d inside {S_WR_DATA, S_RD_DATA});
            oe_q         <= state_d inside {S_RD_TAR, S_RD_DATA};
        end
    end

    pci_target_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (xfer && (state_q == S_WR_DATA)),
        .waddr (word_ptr_q),
        .wdata (AD_in),
        .wstrb (~C_BE_),
        .raddr (word_ptr_q),
        .rdata (rf_rdata)
    );

    assign DEVSEL_ = devsel_q;
    assign TRDY_   = trdy_q;
    assign AD_oe   = oe_q;
    assign AD_out  = oe_q ? rf_rdata : 32'h0;

endmodule

// File: tb/tb_pci_target.sv
// Directed bench for pci_target: writes, wrapping reads, wait states, ignored cycles,
// and reset abort. Inputs change on the falling edge; outputs are checked there too.
module tb_pci_target;

    logic        clk = 1'b0;
    logic        reset;
    logic        FRAME_, IRDY_;
    logic [3:0]  C_BE_;
    logic [31:0] AD_in, AD_out;
    logic        AD_oe, DEVSEL_, TRDY_;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wd [4];
    logic [3:0]  wb [4];
    logic [31:0] rd [4];

    always #5 clk = ~clk;

    pci_target #(.BASE_ADDR(32'h0000_1000)) dut (
        .clk     (clk),
        .reset   (reset),
        .FRAME_  (FRAME_),
        .IRDY_   (IRDY_),
        .C_BE_   (C_BE_),
        .AD_in   (AD_in),
        .AD_out  (AD_out),
        .AD_oe   (AD_oe),
        .DEVSEL_ (DEVSEL_),
        .TRDY_   (TRDY_)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk_bus(input string tag, input logic dv, input logic tr, input logic oe,
                           input logic [31:0] ad);
        check_eq({tag, "/devsel"}, {31'd0, DEVSEL_}, {31'd0, dv});
        check_eq({tag, "/trdy"},   {31'd0, TRDY_},   {31'd0, tr});
        check_eq({tag, "/ad_oe"},  {31'd0, AD_oe},   {31'd0, oe});
        check_eq({tag, "/ad_out"}, AD_out, ad);
    endtask

    task automatic bus_idle();
        FRAME_ = 1'b1; IRDY_ = 1'b1; C_BE_ = 4'h0; AD_in = 32'h0;
    endtask

    task automatic write_burst(input string tag, input logic [31:0] addr, input int n);
        @(negedge clk);
        FRAME_ = 1'b0; AD_in = addr; C_BE_ = 4'b0111; IRDY_ = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_bus({tag, "/beat"}, 1'b0, 1'b0, 1'b0, 32'h0);
            AD_in = wd[i]; C_BE_ = wb[i]; IRDY_ = 1'b0; FRAME_ = (i == n - 1);
        end
        @(negedge clk);
        chk_bus({tag, "/backoff"}, 1'b1, 1'b1, 1'b0, 32'h0);
        bus_idle();
        @(negedge clk);
        chk_bus({tag, "/idle"}, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic read_burst(input string tag, input logic [31:0] addr, input int n,
                              input int stall);
        @(negedge clk);
        FRAME_ = 1'b0; AD_in = addr; C_BE_ = 4'b0110; IRDY_ = 1'b1;
        @(negedge clk);
        check_eq({tag, "/tar_devsel"}, {31'd0, DEVSEL_}, 32'd0);
        check_eq({tag, "/tar_trdy"},   {31'd0, TRDY_},   32'd1);
        check_eq({tag, "/tar_oe"},     {31'd0, AD_oe},   32'd1);
        AD_in = 32'h0; C_BE_ = 4'h0; IRDY_ = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_bus($sformatf("%s/beat%0d", tag, i), 1'b0, 1'b0, 1'b1, rd[i]);
            if (i == stall) begin
                IRDY_ = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    chk_bus($sformatf("%s/wait%0d", tag, i), 1'b0, 1'b0, 1'b1, rd[i]);
                end
                IRDY_ = 1'b0;
            end
            FRAME_ = (i == n - 1);
        end
        @(negedge clk);
        chk_bus({tag, "/backoff"}, 1'b1, 1'b1, 1'b0, 32'h0);
        bus_idle();
        @(negedge clk);
        chk_bus({tag, "/idle"}, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic ignored_cycle(input string tag, input logic [31:0] addr, input logic [3:0] cmd);
        @(negedge clk);
        FRAME_ = 1'b0; AD_in = addr; C_BE_ = cmd; IRDY_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bus({tag, "/busy"}, 1'b1, 1'b1, 1'b0, 32'h0);
            AD_in = 32'h1234_5678; C_BE_ = 4'h0; IRDY_ = 1'b0;
        end
        FRAME_ = 1'b1;
        @(negedge clk);
        chk_bus({tag, "/last"}, 1'b1, 1'b1, 1'b0, 32'h0);
        bus_idle();
        @(negedge clk);
        chk_bus({tag, "/idle"}, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus_idle();
        #3;
        chk_bus("reset_async", 1'b1, 1'b1, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk_bus("reset_clocked", 1'b1, 1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk_bus("post_reset", 1'b1, 1'b1, 1'b0, 32'h0);

        // Single write to entry 1, then read it back.
        wd = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
        wb = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        write_burst("wr_single", 32'h0000_1004, 1);
        rd = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
        read_burst("rd_entry1", 32'h0000_1004, 1, -1);

        // Byte-lane write onto the still-zero entry 0.
        wd = '{32'hAABB_CCDD, 32'h0, 32'h0, 32'h0};
        wb = '{4'b1010, 4'b0000, 4'b0000, 4'b0000};
        write_burst("wr_partial", 32'h0000_1000, 1);
        rd = '{32'h00BB_00DD, 32'h0, 32'h0, 32'h0};
        read_burst("rd_partial", 32'h0000_1000, 1, -1);

        // Preload, then a wrapping read starting at entry 3.
        wd = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        wb = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        write_burst("wr_preload", 32'h0000_1000, 4);
        rd = '{32'h4444_4444, 32'h1111_1111, 32'h2222_2222, 32'h0};
        read_burst("rd_wrap", 32'h0000_100C, 3, -1);

        // Initiator wait states in the middle of a burst.
        rd = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        read_burst("rd_stall", 32'h0000_1000, 4, 1);

        ignored_cycle("ign_addr", 32'h0000_2000, 4'b0110);
        ignored_cycle("ign_cmd",  32'h0000_1000, 4'b0010);
        rd = '{32'h2222_2222, 32'h0, 32'h0, 32'h0};
        read_burst("rd_after_ign", 32'h0000_1004, 1, -1);

        // Reset lands during the second beat of a write burst.
        @(negedge clk);
        FRAME_ = 1'b0; AD_in = 32'h0000_1000; C_BE_ = 4'b0111; IRDY_ = 1'b1;
        @(negedge clk);
        AD_in = 32'h5555_0000; C_BE_ = 4'h0; IRDY_ = 1'b0;
        @(negedge clk);
        chk_bus("abort/beat1", 1'b0, 1'b0, 1'b0, 32'h0);
        AD_in = 32'h5555_0001;
        #2 reset = 1'b1;
        #1 chk_bus("abort/async", 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk_bus("abort/held", 1'b1, 1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        AD_in = 32'h5555_0002;
        @(negedge clk);
        chk_bus("abort/beat2", 1'b1, 1'b1, 1'b0, 32'h0);
        AD_in = 32'h5555_0003;
        @(negedge clk);
        chk_bus("abort/beat3", 1'b1, 1'b1, 1'b0, 32'h0);
        bus_idle();
        @(negedge clk);
        rd = '{32'h0, 32'h0, 32'h0, 32'h0};
        read_burst("rd_after_abort", 32'h0000_1000, 4, -1);

        wd = '{32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
        wb = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
        write_burst("wr_after_abort", 32'h0000_1008, 1);
        rd = '{32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
        read_burst("rd_final", 32'h0000_1008, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pci_target.md
PCI_TARGET -- requirements
Module: pci_target

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, 16-byte-aligned target address window base.
REQ-002 clk  input  1  bus clock; all sampling and output updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 FRAME_  input  1  initiator frame, active low.
REQ-005 IRDY_  input  1  initiator ready, active low.
REQ-006 C_BE_  input  4  command in address phase; active-low byte enables in data phase.
REQ-007 AD_in  input  32  sampled address/data bus.
REQ-008 AD_out  output  32  read data driven by target.
REQ-009 AD_oe  output  1  high while target drives AD.
REQ-010 DEVSEL_  output  1  device select, active low, registered.
REQ-011 TRDY_  output  1  target ready, active low, registered.

Function
REQ-012 Address phase is the rising edge where FRAME_==0 and the previous sampled FRAME_==1, in state IDLE; the block latches AD_in and C_BE_ there.
REQ-013 Claim occurs only if AD_in[31:4]==BASE_ADDR[31:4] and C_BE_ is 4'b0110 (mem read) or 4'b0111 (mem write); otherwise go to IGNORE.
REQ-014 States: IDLE, WR_DATA, RD_TAR, RD_DATA, BACKOFF, IGNORE (enum in package).
REQ-015 IDLE->WR_DATA on claimed write: DEVSEL_=0 and TRDY_=0 in the next cycle (fast decode).
REQ-016 IDLE->RD_TAR on claimed read: DEVSEL_=0, TRDY_=1, AD_oe=1 next cycle; RD_TAR->RD_DATA unconditionally after one cycle, with TRDY_=0 and AD_out valid.
REQ-017 A data transfer occurs on each edge sampling IRDY_==0 and TRDY_==0; no other edge transfers data.
REQ-018 Write transfer: write AD_in into entry word_ptr, only the byte lanes where C_BE_[i]==0.
REQ-019 Read transfer: AD_out then presents the next entry by the following cycle; AD_out holds stable while IRDY_==1 (initiator wait state).
REQ-020 word_ptr = latched AD[3:2], increments by 1 per transfer, wraps 3->0 (4-entry register file, burst of any length).
REQ-021 TRDY_ shall never be 0 while DEVSEL_ is 1; AD_out and AD_oe shall never be X while TRDY_==0.
REQ-022 Transfer sampled with FRAME_==1 is the last: go to BACKOFF, where DEVSEL_=1, TRDY_=1, AD_oe=0 for one cycle, then IDLE.
REQ-023 IGNORE: all outputs deasserted; return to IDLE on the first edge sampling FRAME_==1 and IRDY_==1.
REQ-024 A new FRAME_ falling edge during any non-IDLE state is ignored (no re-claim).
REQ-025 AD_out = 0 whenever AD_oe==0.

Reset
REQ-026 While reset==1: state IDLE, DEVSEL_=1, TRDY_=1, AD_oe=0, AD_out=0, word_ptr=0, all registers 0, regardless of clk.
REQ-027 Reset asserted mid-transaction aborts it immediately with no further register write; after release the block waits in IDLE for a fresh FRAME_ falling edge.

Structure
REQ-028 Package pci_target_pkg holds the state enum, command constants CMD_MEM_READ=4'b0110 and CMD_MEM_WRITE=4'b0111, and register-file depth 4.
REQ-029 Sub-module pci_target_regfile: 4x32 storage, byte-enabled synchronous write, combinational read, async-high reset to 0.

Verification
REQ-030 Single write at 32'h0000_1004, data 32'hDEAD_BEEF, C_BE_=4'b0000, FRAME_ high with IRDY_ low -> DEVSEL_/TRDY_ low one cycle after address, entry1=32'hDEAD_BEEF, BACKOFF one cycle.
REQ-031 Burst read at 32'h0000_100C, 3 words after preloading entries with 11111111/22222222/33333333/44444444 -> RD_TAR cycle with TRDY_ high, then 44444444, 11111111, 22222222 (wrap).
REQ-032 Partial write of 32'hAABBCCDD with C_BE_=4'b1010 to entry0=0 -> entry0=32'h00BB00DD.
REQ-033 Read with IRDY_ held high 2 cycles mid-burst -> AD_out and TRDY_ stable, word_ptr unchanged until IRDY_ low.
REQ-034 Address 32'h0000_2000 or command 4'b0010 -> DEVSEL_ stays 1 throughout, IGNORE until bus idle.
REQ-035 Reset pulse during second beat of a write burst -> outputs deasserted same cycle, remaining beats not written, next transaction claimed normally.
